inv_rx_debounce: RTL
====================

// Module: inv_rx_debounce
//
// PURPOSE
// Receive end of an inverter-driven single-bit line: takes the raw asynchronous
// level driven by an inverter stage, restores its polarity and synchronises it
// into the clk domain. Debounces the result and reports a clean level, 1-cycle
// rise/fall strobes, and a saturating count of rejected glitches.
// Sits between switch-level/pad logic and synchronous control logic.
//
// PARAMETERS
// SYNC_STAGES      2   synchroniser flops (>=2)
// DEBOUNCE_CYCLES  16  cycles a new synced value must persist to commit (>=2)
// INVERT_IN        1   1: vin arrives inverted, internal value = ~vin; 0: pass-through
// CNT_W            $clog2(DEBOUNCE_CYCLES+1)  debounce counter width (derived)
//
// PORTS
// clk         in   1  clock; all logic on posedge
// rst_n       in   1  asynchronous, active-low reset
// vin         in   1  raw asynchronous line from inverter output
// en          in   1  1: debounce active; 0: hold level, abort any check
// clr_glitch  in   1  synchronous clear of glitch_cnt
// level       out  1  debounced, polarity-restored level
// rise        out  1  1-cycle strobe when level commits 0->1
// fall        out  1  1-cycle strobe when level commits 1->0
// busy        out  1  high while FSM is in a CHK state
// glitch_cnt  out  8  rejected transitions, saturates at 255
//
// BEHAVIOUR
// - Reset (rst_n=0, async): sync chain = value giving internal 0 (all 1s if
//   INVERT_IN=1); level=0, rise=fall=busy=0, glitch_cnt=0, cnt=0, state=IDLE_LO.
//   Reset mid-check discards the check; no strobe, no glitch count.
// - s = last sync stage output, after INVERT_IN polarity applied.
// - FSM states: IDLE_LO, CHK_HI, IDLE_HI, CHK_LO.
//   IDLE_LO: s=1 & en -> CHK_HI, cnt=1.   IDLE_HI: s=0 & en -> CHK_LO, cnt=1.
//   CHK_x: s still differs from level -> cnt++; when cnt==DEBOUNCE_CYCLES-1 and
//   s still differs, commit: toggle level, pulse rise/fall for exactly one cycle
//   (registered, same edge level changes), go to opposite IDLE, cnt=0.
//   CHK_x: s returns to level -> abort to IDLE, cnt=0, glitch_cnt++ (sat. 255).
// - level commits DEBOUNCE_CYCLES cycles after s first differs; total latency
//   from first clk edge sampling new vin = SYNC_STAGES+DEBOUNCE_CYCLES edges.
// - en=0: sync chain keeps running; FSM forced to IDLE matching level, cnt=0,
//   no strobe, no glitch count. Re-enable restarts check from cnt=1 if s differs.
// - clr_glitch and a glitch abort in same cycle: glitch_cnt=0 (clear wins).
// - rise and fall never both high; busy = state is CHK_HI or CHK_LO.
// - No combinational path from any input to any output.
//
// TESTING (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, INVERT_IN=1)
// 1. rst_n=0 with vin toggling -> level=0, rise=fall=busy=0, glitch_cnt=0 throughout.
// 2. vin 1->0 held 10 cycles -> level=1 exactly 6 edges after first sampling
//    edge, rise=1 for one cycle; vin 0->1 held -> level=0 after 6, fall pulse.
// 3. vin low for 2 cycles then back high -> level stays 0, no strobe, glitch_cnt=1.
// 4. 300 short glitches -> glitch_cnt=255 (no wrap); clr_glitch=1 -> 0;
//    clr_glitch coincident with glitch abort -> 0.
// 5. rst_n dropped while busy=1 -> all outputs 0 immediately, no rise/fall later.
// 6. en=0, vin 1->0 held 10 cycles -> level=0, busy=0; en=1 -> level=1 four
//    cycles later with single rise strobe.

Source files
------------

// File: rtl/inv_rx_debounce.sv
// Receive end of an inverter-driven line: restores polarity, synchronises,
// debounces, and reports level, rise/fall strobes and a glitch count.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   vin             raw asynchronous line from the inverter output
//   en              1: debounce active; 0: hold level, abort any check
//   clr_glitch      synchronous clear of glitch_cnt
//   level           debounced, polarity-restored level
//   rise, fall      1-cycle strobes on a committed 0->1 / 1->0 change
//   busy            high while a change is being qualified
//   glitch_cnt      rejected transitions, saturating at 255
module inv_rx_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter bit INVERT_IN       = 1'b1,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vin,
  input  logic       en,
  input  logic       clr_glitch,
  output logic       level,
  output logic       rise,
  output logic       fall,
  output logic       busy,
  output logic [7:0] glitch_cnt
);

  typedef enum logic [1:0] {
    IDLE_LO,
    CHK_HI,
    IDLE_HI,
    CHK_LO
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // Reset value of the chain is the raw level that means internal 0.
  localparam logic [SYNC_STAGES-1:0] SYNC_RST =
    {SYNC_STAGES{INVERT_IN}};

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_level;
  logic                   r_rise;
  logic                   r_fall;
  logic [7:0]             r_glitch;

  logic                   w_s;
  state_t                 w_state_nxt;
  logic [CNT_W-1:0]       w_cnt_nxt;
  logic                   w_level_nxt;
  logic                   w_rise_nxt;
  logic                   w_fall_nxt;
  logic                   w_glitch_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= SYNC_RST;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], vin};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ INVERT_IN;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_level_nxt  = r_level;
    w_rise_nxt   = 1'b0;
    w_fall_nxt   = 1'b0;
    w_glitch_inc = 1'b0;
    if (!en) begin
      w_state_nxt = r_level ? IDLE_HI : IDLE_LO;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE_LO: begin
          if (w_s) begin
            w_state_nxt = CHK_HI;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        CHK_HI: begin
          if (!w_s) begin
            w_state_nxt  = IDLE_LO;
            w_cnt_nxt    = '0;
            w_glitch_inc = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_HI;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!w_s) begin
            w_state_nxt = CHK_LO;
            w_cnt_nxt   = CNT_ONE;
          end
        end
        CHK_LO: begin
          if (w_s) begin
            w_state_nxt  = IDLE_HI;
            w_cnt_nxt    = '0;
            w_glitch_inc = 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            w_state_nxt = IDLE_LO;
            w_cnt_nxt   = '0;
            w_level_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE_LO;
          w_cnt_nxt   = '0;
          w_level_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  // Clear has priority over a same-cycle abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_glitch <= '0;
    end else if (clr_glitch) begin
      r_glitch <= '0;
    end else if (w_glitch_inc && r_glitch != 8'hFF) begin
      r_glitch <= r_glitch + 8'd1;
    end
  end

  assign level      = r_level;
  assign rise       = r_rise;
  assign fall       = r_fall;
  assign busy       = (r_state == CHK_HI) || (r_state == CHK_LO);
  assign glitch_cnt = r_glitch;

endmodule
